ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-requester arbiter sharing the single-port on-chip SRAM of the Arty A7 SoC between the Ibex instruction fetch port and the Ibex data port. It sits between the core's req/gnt/rvalid bus ports and the RAM macro. It decodes the RAM window, grants one access per cycle with round-robin fairness, routes the one-cycle-latency read data back to the granted requester, and flags out-of-window accesses as bus errors. A saturating conflict counter is exposed for debug.

## Interface
Parameters:
- MEM_SIZE, 65536, RAM size in bytes; power of two, at least 8.
- MEM_START, 32'h00000000, byte base address of the RAM window; MEM_SIZE-aligned.
- MEM_MASK, MEM_SIZE-1, byte offset mask.
- AW, $clog2(MEM_SIZE)-2, word address width toward the RAM.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- srst  in  1  synchronous reset, active-high.
- instr_req_i  in  1  instruction fetch request (read only).
- instr_addr_i  in  32  fetch byte address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch read data.
- instr_err_o  out  1  fetch bus error; qualified by rvalid.
- data_req_i  in  1  data request.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_addr_i  in  32  data byte address.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  data request accepted this cycle.
- data_rvalid_o  out  1  data response valid; asserted for both reads and writes.
- data_rdata_o  out  32  data read data.
- data_err_o  out  1  data bus error; qualified by rvalid.
- mem_req_o  out  1  RAM access strobe.
- mem_we_o  out  1  RAM write enable.
- mem_be_o  out  4  RAM byte enables.
- mem_addr_o  out  AW  RAM word address.
- mem_wdata_o  out  32  RAM write data.
- mem_rdata_i  in  32  RAM read data, valid exactly one cycle after mem_req_o.
- conflict_cnt_o  out  16  number of cycles in which both requesters asked; saturates at 16'hFFFF.

## Operation
- In-window test: addr[31:0] & ~MEM_MASK == MEM_START.
- RAM word address: (addr & MEM_MASK) >> 2.
- Grant is combinational from req and the registered priority bit. At most one gnt per cycle.
- Single requester: that requester is granted in the same cycle it asks.
- Both requesting: the requester that was not granted last wins.
- Priority bit (last_granted) updates on every grant. After reset it is set so that data wins the first conflict.
- Granted and in-window: mem_req_o=1. mem_we/be/wdata come from the data port when data is granted. For instr grants, mem_we_o=0 and mem_be_o=4'hF.
- Granted and out-of-window: mem_req_o=0, no RAM access; an error response is issued.
- When mem_req_o=0, mem_we_o=0 and the other mem_* outputs are don't-care.
- Response registers capture grant owner, error flag and valid:
  - The cycle after a grant, the owner's rvalid is 1 and the other requester's rvalid is 0.
  - rdata = mem_rdata_i for an in-window read; 32'h0 for errors and writes.
  - err = 1 for out-of-window.
- conflict_cnt increments in every cycle where instr_req_i and data_req_i are both 1, saturating.
- Ungranted requesters must hold their request; no buffering of ungranted requests is required.

## Timing
- Reset values: all rvalid=0, err=0, rdata=0, conflict_cnt=0, last_granted=instr.
- gnt and mem_* outputs are combinational and follow inputs in the same cycle; while srst=1 they are all forced to 0.
- Latency is fixed: grant in cycle N, response in cycle N+1. Throughput is one access per cycle with no bubbles.
- Back-to-back grants to the same requester are allowed when the other requester is idle.
- srst asserted in cycle N+1 after a grant in cycle N: the pending rvalid is suppressed and no response is ever delivered.
- A grant and a response to the same requester in the same cycle is legal.

## Test plan
- Fetch only: instr_addr=32'h100 with RAM word 64 = 32'hDEADBEEF -> gnt same cycle, mem_addr=64, next cycle instr_rvalid=1, rdata=32'hDEADBEEF, err=0.
- Data write then read: write 32'h12345678, be=4'b0011 at 32'h20 -> data_rvalid next cycle with err=0 and rdata=0; read back -> 32'h00005678 (RAM preloaded 0).
- Continuous conflict for 6 cycles from reset -> grants alternate data, instr, data, instr, data, instr; conflict_cnt=6.
- Out-of-window: data read at 32'h0001_0000 (MEM_SIZE=64K) -> gnt=1, mem_req=0, next cycle data_rvalid=1, err=1, rdata=0.
- Reset mid-operation: grant instr in cycle N, srst=1 in N+1 -> instr_rvalid stays 0; after release conflict_cnt=0 and data wins the first conflict.
- Saturation: hold both requests for 65540 cycles -> conflict_cnt=16'hFFFF and remains there.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the Ibex fetch and data ports.
// Grants and RAM strobes are combinational; responses are registered one cycle after the grant.
module ram_port_arbiter #(
    parameter int unsigned  MEM_SIZE  = 65536,
    parameter logic [31:0]  MEM_START = 32'h0000_0000,
    parameter logic [31:0]  MEM_MASK  = MEM_SIZE - 1,
    parameter int           AW        = $clog2(MEM_SIZE) - 2
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          instr_req_i,
    input  logic [31:0]   instr_addr_i,
    output logic          instr_gnt_o,
    output logic          instr_rvalid_o,
    output logic [31:0]   instr_rdata_o,
    output logic          instr_err_o,
    input  logic          data_req_i,
    input  logic          data_we_i,
    input  logic [3:0]    data_be_i,
    input  logic [31:0]   data_addr_i,
    input  logic [31:0]   data_wdata_i,
    output logic          data_gnt_o,
    output logic          data_rvalid_o,
    output logic [31:0]   data_rdata_o,
    output logic          data_err_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i,
    output logic [15:0]   conflict_cnt_o
);

    function automatic logic addr_in_window(input logic [31:0] addr);
        return (addr & ~MEM_MASK) == MEM_START;
    endfunction

    logic        grant_instr_s;
    logic        grant_data_s;
    logic        grant_any_s;
    logic        both_req_s;
    logic [31:0] sel_addr_s;
    logic [31:0] offset_s;
    logic        in_window_s;
    logic        last_data_r;
    logic        resp_valid_r;
    logic        resp_data_r;
    logic        resp_err_r;
    logic        resp_we_r;
    logic [15:0] conflict_cnt_r;
    logic        instr_valid_s;
    logic        data_valid_s;
    logic        read_hit_s;

    assign both_req_s  = instr_req_i & data_req_i;
    assign grant_any_s = grant_instr_s | grant_data_s;
    assign sel_addr_s  = grant_data_s ? data_addr_i : instr_addr_i;
    assign offset_s    = sel_addr_s & MEM_MASK;
    assign in_window_s = addr_in_window(sel_addr_s);

    // Grant selection: on a conflict the requester not served last wins
    always_comb begin
        grant_instr_s = 1'b0;
        grant_data_s  = 1'b0;
        if (srst) begin
            grant_instr_s = 1'b0;
            grant_data_s  = 1'b0;
        end else if (both_req_s) begin
            if (last_data_r) begin
                grant_instr_s = 1'b1;
            end else begin
                grant_data_s = 1'b1;
            end
        end else if (instr_req_i) begin
            grant_instr_s = 1'b1;
        end else if (data_req_i) begin
            grant_data_s = 1'b1;
        end else begin
            grant_instr_s = 1'b0;
            grant_data_s  = 1'b0;
        end
    end

    // RAM strobe and routing of the granted request
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'h0;
        if (grant_any_s && in_window_s) begin
            mem_req_o  = 1'b1;
            mem_addr_o = offset_s[AW+1:2];
            if (grant_data_s) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_we_o    = 1'b0;
                mem_be_o    = 4'hF;
                mem_wdata_o = 32'h0;
            end
        end else begin
            mem_req_o = 1'b0;
        end
    end

    // Priority bit, response capture and saturating conflict counter
    always_ff @(posedge clk) begin
        if (srst) begin
            last_data_r    <= 1'b0;
            resp_valid_r   <= 1'b0;
            resp_data_r    <= 1'b0;
            resp_err_r     <= 1'b0;
            resp_we_r      <= 1'b0;
            conflict_cnt_r <= 16'h0;
        end else begin
            resp_valid_r <= grant_any_s;
            resp_data_r  <= grant_data_s;
            resp_err_r   <= grant_any_s & ~in_window_s;
            resp_we_r    <= grant_data_s & data_we_i;
            if (grant_any_s) begin
                last_data_r <= grant_data_s;
            end
            if (both_req_s && (conflict_cnt_r != 16'hFFFF)) begin
                conflict_cnt_r <= conflict_cnt_r + 16'd1;
            end
        end
    end

    // srst in the response cycle swallows the pending response
    assign instr_valid_s  = resp_valid_r & ~resp_data_r & ~srst;
    assign data_valid_s   = resp_valid_r & resp_data_r & ~srst;
    assign read_hit_s     = ~resp_err_r & ~resp_we_r;

    assign instr_gnt_o    = grant_instr_s;
    assign data_gnt_o     = grant_data_s;
    assign instr_rvalid_o = instr_valid_s;
    assign instr_err_o    = instr_valid_s & resp_err_r;
    assign instr_rdata_o  = (instr_valid_s && read_hit_s) ? mem_rdata_i : 32'h0;
    assign data_rvalid_o  = data_valid_s;
    assign data_err_o     = data_valid_s & resp_err_r;
    assign data_rdata_o   = (data_valid_s && read_hit_s) ? mem_rdata_i : 32'h0;
    assign conflict_cnt_o = conflict_cnt_r;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and randomized bench for ram_port_arbiter with a transaction-level reference model
// and a behavioural one-cycle-latency RAM attached to the mem_* port.
module tb_ram_port_arbiter;

    localparam logic [31:0] MASK  = 32'h0000_FFFF;
    localparam logic [31:0] START = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        srst;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [13:0] mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic [15:0] conflict_cnt_o;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter dut (
        .clk(clk), .srst(srst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .conflict_cnt_o(conflict_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Environment RAM: one-cycle read latency, byte-enabled writes
    bit [31:0] ram [0:16383];
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) ram[mem_addr_o] <= merge(ram[mem_addr_o], mem_wdata_o, mem_be_o);
            mem_rdata_i <= ram[mem_addr_o];
        end
    end

    // Reference model state: memory image, fairness, pending response, counter
    bit [31:0] ref_mem [0:16383];
    bit        ref_last_data;
    int        ref_cnt;
    bit        pv, po_data, perr;
    logic [31:0] prdata;
    bit        hold_i, hold_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit ir, input logic [31:0] ia, input bit dr,
                         input bit we, input logic [3:0] be, input logic [31:0] da,
                         input logic [31:0] wd);
        srst = rst; instr_req_i = ir; instr_addr_i = ia;
        data_req_i = dr; data_we_i = we; data_be_i = be; data_addr_i = da; data_wdata_i = wd;
    endtask

    task automatic cycle();
        bit gi, gd, both, win, iv, dv;
        logic [31:0] a, off;
        @(negedge clk);
        both = instr_req_i && data_req_i;
        gi = 1'b0; gd = 1'b0;
        if (!srst) begin
            if (both) begin
                if (ref_last_data) gi = 1'b1; else gd = 1'b1;
            end else if (instr_req_i) gi = 1'b1;
            else if (data_req_i) gd = 1'b1;
        end
        a   = gd ? data_addr_i : instr_addr_i;
        win = ((a & ~MASK) == START);
        off = a & MASK;
        chk("instr_gnt", 32'(instr_gnt_o), 32'(gi));
        chk("data_gnt", 32'(data_gnt_o), 32'(gd));
        chk("mem_req", 32'(mem_req_o), 32'((gi || gd) && win));
        chk("mem_we", 32'(mem_we_o), 32'(gd && win && data_we_i));
        if ((gi || gd) && win) begin
            chk("mem_addr", 32'(mem_addr_o), off >> 2);
            chk("mem_be", 32'(mem_be_o), gd ? 32'(data_be_i) : 32'hF);
            if (gd && data_we_i) chk("mem_wdata", mem_wdata_o, data_wdata_i);
        end
        iv = !srst && pv && !po_data;
        dv = !srst && pv && po_data;
        chk("instr_rvalid", 32'(instr_rvalid_o), 32'(iv));
        chk("instr_err", 32'(instr_err_o), 32'(iv && perr));
        chk("instr_rdata", instr_rdata_o, iv ? prdata : 32'h0);
        chk("data_rvalid", 32'(data_rvalid_o), 32'(dv));
        chk("data_err", 32'(data_err_o), 32'(dv && perr));
        chk("data_rdata", data_rdata_o, dv ? prdata : 32'h0);
        chk("conflict_cnt", 32'(conflict_cnt_o), ref_cnt);
        if (srst) begin
            pv = 1'b0; ref_last_data = 1'b0; ref_cnt = 0; hold_i = 1'b0; hold_d = 1'b0;
        end else begin
            pv = gi || gd; po_data = gd; perr = pv && !win; prdata = 32'h0;
            if (pv && win) begin
                if (gd && data_we_i) ref_mem[off[15:2]] = merge(ref_mem[off[15:2]], data_wdata_i, data_be_i);
                else prdata = ref_mem[off[15:2]];
            end
            if (pv) ref_last_data = gd;
            if (both && ref_cnt < 65535) ref_cnt++;
            hold_i = instr_req_i && !gi;
            hold_d = data_req_i && !gd;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        pv = 1'b0; ref_last_data = 1'b0; ref_cnt = 0; hold_i = 1'b0; hold_d = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        cycle(); cycle();
        chk("reset_cnt", 32'(conflict_cnt_o), 32'h0);
        chk("reset_rvalid", 32'(instr_rvalid_o | data_rvalid_o), 32'h0);

        // Preload word 64, then fetch it
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
        cycle();
        drive(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle();
        chk("fetch_rvalid", 32'(instr_rvalid_o), 32'h1);
        chk("fetch_rdata", instr_rdata_o, 32'hDEADBEEF);

        // Partial write then read back
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h12345678);
        cycle();
        chk("write_rvalid", 32'(data_rvalid_o), 32'h1);
        chk("write_rdata", data_rdata_o, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        cycle();
        chk("readback", data_rdata_o, 32'h00005678);

        // Out-of-window data read
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0);
        cycle();
        chk("oow_err", 32'(data_err_o), 32'h1);
        chk("oow_rdata", data_rdata_o, 32'h0);

        // Reset right after a fetch grant: response is swallowed
        drive(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle();
        chk("rst_rvalid", 32'(instr_rvalid_o), 32'h0);

        // Six conflict cycles from reset alternate starting with data
        drive(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #0 chk("alt_dgnt", 32'(data_gnt_o), 32'((i % 2) == 0));
            cycle();
        end
        chk("conflict6", 32'(conflict_cnt_o), 32'd6);

        // Randomized traffic with occasional resets, honouring the hold rule
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ia, da;
            ia = ($urandom_range(0, 15) == 0) ? (32'h0002_0000 | $urandom_range(0, 255))
                                              : 32'($urandom_range(0, 255));
            da = ($urandom_range(0, 15) == 0) ? (32'h0001_0000 | $urandom_range(0, 255))
                                              : 32'($urandom_range(0, 255));
            if (!hold_i) begin
                instr_req_i = ($urandom_range(0, 2) != 0); instr_addr_i = ia;
            end
            if (!hold_d) begin
                data_req_i = ($urandom_range(0, 2) != 0); data_we_i = $urandom_range(0, 1) == 1;
                data_be_i = 4'($urandom_range(0, 15)); data_addr_i = da; data_wdata_i = $urandom;
            end
            srst = ($urandom_range(0, 63) == 0);
            cycle();
        end

        // Counter saturation
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle();
        drive(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
        for (int i = 0; i < 65540; i++) cycle();
        chk("sat_cnt", 32'(conflict_cnt_o), 32'h0000FFFF);
        cycle();
        chk("sat_hold", 32'(conflict_cnt_o), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
